// File: rtl/soc_mem_pkg.sv
// Shared types for the SoC memory arbiter: source ids, VPU X-IF memory
// request/result structs and the in-flight tag carried through the
// read-latency pipeline.
package soc_mem_pkg;

    localparam int NUM_SRC = 3;
    localparam int X_ID_W  = 4;

    typedef enum logic [1:0] {
        SRC_VPU   = 2'd0,
        SRC_DATA  = 2'd1,
        SRC_INSTR = 2'd2
    } src_e;

    typedef struct packed {
        logic [31:0]       addr;
        logic              we;
        logic [3:0]        be;
        logic [31:0]       wdata;
        logic [X_ID_W-1:0] id;
    } x_mem_req_t;

    typedef struct packed {
        logic [31:0]       rdata;
        logic [X_ID_W-1:0] id;
        logic              err;
    } x_mem_result_t;

    typedef struct packed {
        logic              valid;
        src_e              src;
        logic              we;
        logic              err;
        logic [X_ID_W-1:0] id;
    } mem_tag_t;

    // Next source index in round-robin order 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] rr_next(input logic [1:0] s);
        logic [1:0] n;
        if (s == 2'd2) begin
            n = 2'd0;
        end else begin
            n = s + 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// 3-way round-robin arbiter. The winner is the first requester at or after
// the pointer; the pointer moves past the winner on every grant and holds
// when nothing is granted. Grant is combinational (same-cycle handshake).
module mem_rr_arbiter
    import soc_mem_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] req_i,
    output logic [NUM_SRC-1:0] gnt_o,
    output logic [1:0]         win_o,
    output logic               any_o
);

    logic [1:0]         ptr_q;
    logic [1:0]         ptr_d;
    logic [1:0]         cand_s;
    logic [1:0]         win_s;
    logic               any_s;
    logic [NUM_SRC-1:0] gnt_s;

    // Scan requesters starting at the pointer and pick the first one asserted
    always_comb begin
        gnt_s  = '0;
        win_s  = ptr_q;
        any_s  = 1'b0;
        cand_s = ptr_q;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!any_s && req_i[cand_s]) begin
                gnt_s[cand_s] = 1'b1;
                win_s         = cand_s;
                any_s         = 1'b1;
            end else begin
                any_s = any_s;
            end
            cand_s = rr_next(cand_s);
        end
    end

    // Next pointer: one past the winner, unchanged when idle
    always_comb begin
        if (any_s) begin
            ptr_d = rr_next(win_s);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register, restarts at the VPU source on reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign gnt_o = gnt_s;
    assign win_o = win_s;
    assign any_o = any_s;

endmodule

// File: rtl/soc_mem_arbiter.sv
// Single-port SRAM arbiter for VPU X-IF mem, CPU data OBI and CPU instr OBI.
// One access per cycle, round-robin. A MEM_LAT-deep tag pipeline follows each
// access so its response is steered back to the originator. Word indices at or
// beyond MEM_WORDS are granted but not sent to the SRAM, and answer with err.
// Optional macro SOC_MEM_ARB_PERF_EN adds per-source grant/stall counters.
module soc_mem_arbiter
    import soc_mem_pkg::*;
#(
    parameter int MEM_WORDS  = 8192,
    parameter int MEM_LAT    = 1,
    parameter int X_ID_WIDTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         vpu_valid_i,
    output logic                         vpu_ready_o,
    input  x_mem_req_t                   vpu_req_i,
    output logic                         vpu_rvalid_o,
    output x_mem_result_t                vpu_result_o,
    input  logic                         data_req_i,
    output logic                         data_gnt_o,
    output logic                         data_rvalid_o,
    input  logic                         data_we_i,
    input  logic [3:0]                   data_be_i,
    input  logic [31:0]                  data_addr_i,
    input  logic [31:0]                  data_wdata_i,
    output logic [31:0]                  data_rdata_o,
    output logic                         data_err_o,
    input  logic                         instr_req_i,
    output logic                         instr_gnt_o,
    output logic                         instr_rvalid_o,
    input  logic [31:0]                  instr_addr_i,
    output logic [31:0]                  instr_rdata_o,
    output logic                         instr_err_o,
    output logic                         mem_en_o,
    output logic                         mem_we_o,
    output logic [3:0]                   mem_be_o,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
    output logic [31:0]                  mem_wdata_o,
    input  logic [31:0]                  mem_rdata_i
`ifdef SOC_MEM_ARB_PERF_EN
    ,
    output logic [31:0]                  perf_grant_o [NUM_SRC],
    output logic [31:0]                  perf_stall_o [NUM_SRC]
`endif
);

    localparam int          AW         = $clog2(MEM_WORDS);
    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

    if ((MEM_LAT != 1) && (MEM_LAT != 2)) begin : g_lat_check
        $fatal(1, "soc_mem_arbiter: MEM_LAT must be 1 or 2");
    end
    if (X_ID_WIDTH != X_ID_W) begin : g_id_check
        $fatal(1, "soc_mem_arbiter: X_ID_WIDTH must match soc_mem_pkg::X_ID_W");
    end

    logic [NUM_SRC-1:0] req_s;
    logic [NUM_SRC-1:0] gnt_s;
    logic [1:0]         win_s;
    logic               any_s;

    logic [31:0]        sel_addr_s;
    logic               sel_we_s;
    logic [3:0]         sel_be_s;
    logic [31:0]        sel_wdata_s;
    logic [X_ID_W-1:0]  sel_id_s;
    logic               oor_s;
    logic               unused_addr_s;

    mem_tag_t           tag_d;
    mem_tag_t           tag_q [MEM_LAT];
    mem_tag_t           tag_out_s;
    logic               rd_ok_s;
    logic [31:0]        rdata_s;

    // No requests are seen while reset is held, so no handshake fires then.
    assign req_s = {instr_req_i, data_req_i, vpu_valid_i} & {NUM_SRC{~rst_i}};

    mem_rr_arbiter u_rr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (req_s),
        .gnt_o (gnt_s),
        .win_o (win_s),
        .any_o (any_s)
    );

    assign vpu_ready_o = gnt_s[SRC_VPU];
    assign data_gnt_o  = gnt_s[SRC_DATA];
    assign instr_gnt_o = gnt_s[SRC_INSTR];

    // Select the request fields of the winning source
    always_comb begin
        sel_addr_s  = 32'h0;
        sel_we_s    = 1'b0;
        sel_be_s    = 4'h0;
        sel_wdata_s = 32'h0;
        sel_id_s    = '0;
        case (win_s)
            2'd0: begin
                sel_addr_s  = vpu_req_i.addr;
                sel_we_s    = vpu_req_i.we;
                sel_be_s    = vpu_req_i.be;
                sel_wdata_s = vpu_req_i.wdata;
                sel_id_s    = vpu_req_i.id;
            end
            2'd1: begin
                sel_addr_s  = data_addr_i;
                sel_we_s    = data_we_i;
                sel_be_s    = data_be_i;
                sel_wdata_s = data_wdata_i;
            end
            2'd2: begin
                sel_addr_s  = instr_addr_i;
                sel_be_s    = 4'hF;
            end
            default: begin
                sel_addr_s  = 32'h0;
            end
        endcase
    end

    // Byte offset within the word plays no part in the access.
    assign unused_addr_s = ^sel_addr_s[1:0];
    assign oor_s         = (sel_addr_s[31:2] >= WORD_LIMIT);

    // Drive the SRAM for an in-range grant; out-of-range accesses never reach it
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = 32'h0;
        if (any_s) begin
            mem_be_o    = sel_be_s;
            mem_addr_o  = sel_addr_s[AW+1:2];
            mem_wdata_o = sel_wdata_s;
            if (!oor_s) begin
                mem_en_o = 1'b1;
                mem_we_o = sel_we_s;
            end else begin
                mem_en_o = 1'b0;
            end
        end else begin
            mem_en_o = 1'b0;
        end
    end

    // Build the tag for this cycle; an empty slot when nothing is granted
    always_comb begin
        tag_d = '0;
        if (any_s) begin
            tag_d.valid = 1'b1;
            tag_d.src   = src_e'(win_s);
            tag_d.we    = sel_we_s;
            tag_d.err   = oor_s;
            tag_d.id    = sel_id_s;
        end else begin
            tag_d.valid = 1'b0;
        end
    end

    // Tag shift register matching the SRAM read latency; reset drops in-flight tags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_d;
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_out_s = tag_q[MEM_LAT-1];

    // Route the oldest in-flight tag back to its originator with the SRAM data
    always_comb begin
        vpu_rvalid_o   = 1'b0;
        vpu_result_o   = '0;
        data_rvalid_o  = 1'b0;
        data_rdata_o   = 32'h0;
        data_err_o     = 1'b0;
        instr_rvalid_o = 1'b0;
        instr_rdata_o  = 32'h0;
        instr_err_o    = 1'b0;
        rd_ok_s        = tag_out_s.valid && !tag_out_s.we && !tag_out_s.err;
        rdata_s        = rd_ok_s ? mem_rdata_i : 32'h0;
        if (!rst_i && tag_out_s.valid) begin
            case (tag_out_s.src)
                SRC_VPU: begin
                    if (!tag_out_s.we) begin
                        vpu_rvalid_o       = 1'b1;
                        vpu_result_o.rdata = rdata_s;
                        vpu_result_o.id    = tag_out_s.id;
                        vpu_result_o.err   = tag_out_s.err;
                    end else begin
                        vpu_rvalid_o = 1'b0;
                    end
                end
                SRC_DATA: begin
                    data_rvalid_o = 1'b1;
                    data_rdata_o  = rdata_s;
                    data_err_o    = tag_out_s.err;
                end
                SRC_INSTR: begin
                    instr_rvalid_o = 1'b1;
                    instr_rdata_o  = rdata_s;
                    instr_err_o    = tag_out_s.err;
                end
                default: begin
                    data_rvalid_o = 1'b0;
                end
            endcase
        end else begin
            vpu_rvalid_o = 1'b0;
        end
    end

`ifdef SOC_MEM_ARB_PERF_EN
    logic [31:0] perf_grant_q [NUM_SRC];
    logic [31:0] perf_stall_q [NUM_SRC];

    // Per-source grant and stall counters, saturating at all-ones
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                perf_grant_q[s] <= 32'h0;
                perf_stall_q[s] <= 32'h0;
            end
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (gnt_s[s] && (perf_grant_q[s] != 32'hFFFF_FFFF)) begin
                    perf_grant_q[s] <= perf_grant_q[s] + 32'h1;
                end else begin
                    perf_grant_q[s] <= perf_grant_q[s];
                end
                if (req_s[s] && !gnt_s[s] && (perf_stall_q[s] != 32'hFFFF_FFFF)) begin
                    perf_stall_q[s] <= perf_stall_q[s] + 32'h1;
                end else begin
                    perf_stall_q[s] <= perf_stall_q[s];
                end
            end
        end
    end

    assign perf_grant_o = perf_grant_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Bench for soc_mem_arbiter: one instance with MEM_LAT=1 and one with
// MEM_LAT=2 share the same stimulus, each behind its own SRAM model.
// A reference model (round-robin by index arithmetic, memory image, queue
// of expected responses) checks every cycle; directed scenarios add checks
// against literal values. Counters are checked when SOC_MEM_ARB_PERF_EN is set.
module tb_soc_mem_arbiter;
    import soc_mem_pkg::*;

    localparam int MEM_WORDS = 8192;
    localparam int AW        = 13;

    typedef struct {
        int          g;
        int          src;
        bit          we;
        bit          err;
        logic [31:0] rdata;
        logic [3:0]  id;
    } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mem_clear;
    logic        vpu_valid;
    x_mem_req_t  vpu_req;
    logic        data_req, data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata;
    logic        instr_req;
    logic [31:0] instr_addr;

    logic          vpu_ready_w [2];
    logic          vpu_rvalid_w [2];
    x_mem_result_t vpu_result_w [2];
    logic          data_gnt_w [2], data_rvalid_w [2], data_err_w [2];
    logic [31:0]   data_rdata_w [2];
    logic          instr_gnt_w [2], instr_rvalid_w [2], instr_err_w [2];
    logic [31:0]   instr_rdata_w [2];
    logic          mem_en_w [2], mem_we_w [2];
    logic [3:0]    mem_be_w [2];
    logic [AW-1:0] mem_addr_w [2];
    logic [31:0]   mem_wdata_w [2], mem_rdata_w [2];
`ifdef SOC_MEM_ARB_PERF_EN
    logic [31:0]   pg_w [2][3];
    logic [31:0]   ps_w [2][3];
`endif

    function automatic logic [31:0] apply_be(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] sram [MEM_WORDS];
        logic [31:0] rd_a_q, rd_b_q;

        soc_mem_arbiter #(.MEM_WORDS(MEM_WORDS), .MEM_LAT(g + 1), .X_ID_WIDTH(4)) u_dut (
            .clk_i          (clk),
            .rst_i          (rst),
            .vpu_valid_i    (vpu_valid),
            .vpu_ready_o    (vpu_ready_w[g]),
            .vpu_req_i      (vpu_req),
            .vpu_rvalid_o   (vpu_rvalid_w[g]),
            .vpu_result_o   (vpu_result_w[g]),
            .data_req_i     (data_req),
            .data_gnt_o     (data_gnt_w[g]),
            .data_rvalid_o  (data_rvalid_w[g]),
            .data_we_i      (data_we),
            .data_be_i      (data_be),
            .data_addr_i    (data_addr),
            .data_wdata_i   (data_wdata),
            .data_rdata_o   (data_rdata_w[g]),
            .data_err_o     (data_err_w[g]),
            .instr_req_i    (instr_req),
            .instr_gnt_o    (instr_gnt_w[g]),
            .instr_rvalid_o (instr_rvalid_w[g]),
            .instr_addr_i   (instr_addr),
            .instr_rdata_o  (instr_rdata_w[g]),
            .instr_err_o    (instr_err_w[g]),
            .mem_en_o       (mem_en_w[g]),
            .mem_we_o       (mem_we_w[g]),
            .mem_be_o       (mem_be_w[g]),
            .mem_addr_o     (mem_addr_w[g]),
            .mem_wdata_o    (mem_wdata_w[g]),
            .mem_rdata_i    (mem_rdata_w[g])
`ifdef SOC_MEM_ARB_PERF_EN
            ,
            .perf_grant_o   (pg_w[g]),
            .perf_stall_o   (ps_w[g])
`endif
        );

        // SRAM model with g+1 cycles of read latency
        always @(posedge clk) begin
            if (mem_clear) begin
                for (int i = 0; i < MEM_WORDS; i++) sram[i] <= 32'h0;
            end else if (mem_en_w[g]) begin
                if (mem_we_w[g]) sram[mem_addr_w[g]] <= apply_be(sram[mem_addr_w[g]], mem_wdata_w[g], mem_be_w[g]);
                else             rd_a_q <= sram[mem_addr_w[g]];
            end
            rd_b_q <= rd_a_q;
        end
        assign mem_rdata_w[g] = (g == 0) ? rd_a_q : rd_b_q;
    end

    // ---------------- reference model and checking ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] ref_mem [MEM_WORDS];
    int          ref_ptr;
    int          cyc;
    int          last_win;
    resp_t       q0[$];
    resp_t       q1[$];
    int          ref_pg [3];
    int          ref_ps [3];

    logic [2:0]    obs_gnt;
    logic          obs_mem_en, obs_vpu_rvalid, obs_data_rvalid, obs_data_err;
    logic [31:0]   obs_data_rdata;
    x_mem_result_t obs_vpu_result;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_resp(input int i);
        resp_t e;
        bit    have;
        logic  ev, ed, ei;
        have = 1'b0;
        ev = 1'b0; ed = 1'b0; ei = 1'b0;
        if (i == 0) begin
            if (q0.size() > 0 && q0[0].g + 1 == cyc) begin e = q0.pop_front(); have = 1'b1; end
        end else begin
            if (q1.size() > 0 && q1[0].g + 2 == cyc) begin e = q1.pop_front(); have = 1'b1; end
        end
        if (have && !rst) begin
            ev = (e.src == 0) && !e.we;
            ed = (e.src == 1);
            ei = (e.src == 2);
        end
        check_eq($sformatf("i%0d_vpu_rvalid", i), vpu_rvalid_w[i], ev);
        check_eq($sformatf("i%0d_data_rvalid", i), data_rvalid_w[i], ed);
        check_eq($sformatf("i%0d_instr_rvalid", i), instr_rvalid_w[i], ei);
        if (ev) begin
            check_eq($sformatf("i%0d_vpu_rdata", i), vpu_result_w[i].rdata, e.rdata);
            check_eq($sformatf("i%0d_vpu_id", i), vpu_result_w[i].id, e.id);
            check_eq($sformatf("i%0d_vpu_err", i), vpu_result_w[i].err, e.err);
        end
        if (ed) begin
            check_eq($sformatf("i%0d_data_rdata", i), data_rdata_w[i], e.rdata);
            check_eq($sformatf("i%0d_data_err", i), data_err_w[i], e.err);
        end
        if (ei) begin
            check_eq($sformatf("i%0d_instr_rdata", i), instr_rdata_w[i], e.rdata);
            check_eq($sformatf("i%0d_instr_err", i), instr_err_w[i], e.err);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, then advance the model.
    task automatic run_cycle();
        logic [2:0]  reqv;
        int          win;
        logic [31:0] f_addr, f_wd;
        logic        f_we, oor, exp_en;
        logic [3:0]  f_be, f_id;
        resp_t       e;
        @(negedge clk);
        obs_gnt         = {instr_gnt_w[0], data_gnt_w[0], vpu_ready_w[0]};
        obs_mem_en      = mem_en_w[0];
        obs_vpu_rvalid  = vpu_rvalid_w[0];
        obs_vpu_result  = vpu_result_w[0];
        obs_data_rvalid = data_rvalid_w[0];
        obs_data_rdata  = data_rdata_w[0];
        obs_data_err    = data_err_w[0];
        for (int i = 0; i < 2; i++) check_resp(i);
`ifdef SOC_MEM_ARB_PERF_EN
        for (int i = 0; i < 2; i++) begin
            for (int s = 0; s < 3; s++) begin
                check_eq($sformatf("i%0d_perf_grant%0d", i, s), pg_w[i][s], ref_pg[s]);
                check_eq($sformatf("i%0d_perf_stall%0d", i, s), ps_w[i][s], ref_ps[s]);
            end
        end
`endif
        reqv = rst ? 3'b000 : {instr_req, data_req, vpu_valid};
        win  = -1;
        for (int k = 0; k < 3; k++) begin
            int s;
            s = (ref_ptr + k) % 3;
            if (win < 0 && reqv[s]) win = s;
        end
        f_addr = 32'h0; f_wd = 32'h0; f_we = 1'b0; f_be = 4'h0; f_id = 4'h0;
        case (win)
            0: begin f_addr = vpu_req.addr; f_we = vpu_req.we; f_be = vpu_req.be; f_wd = vpu_req.wdata; f_id = vpu_req.id; end
            1: begin f_addr = data_addr; f_we = data_we; f_be = data_be; f_wd = data_wdata; end
            2: begin f_addr = instr_addr; f_be = 4'hF; end
            default: f_addr = 32'h0;
        endcase
        oor    = (f_addr[31:2] >= MEM_WORDS);
        exp_en = (win >= 0) && !oor;
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("i%0d_gnt", i), {instr_gnt_w[i], data_gnt_w[i], vpu_ready_w[i]},
                     (win >= 0) ? (3'b001 << win) : 3'b000);
            check_eq($sformatf("i%0d_mem_en", i), mem_en_w[i], exp_en);
            check_eq($sformatf("i%0d_mem_we", i), mem_we_w[i], exp_en && f_we);
            if (exp_en) begin
                check_eq($sformatf("i%0d_mem_addr", i), mem_addr_w[i], f_addr[AW+1:2]);
                check_eq($sformatf("i%0d_mem_be", i), mem_be_w[i], f_be);
                if (f_we) check_eq($sformatf("i%0d_mem_wdata", i), mem_wdata_w[i], f_wd);
            end
        end
        if (rst) begin
            q0.delete();
            q1.delete();
            ref_ptr = 0;
            for (int s = 0; s < 3; s++) begin ref_pg[s] = 0; ref_ps[s] = 0; end
        end else begin
            for (int s = 0; s < 3; s++) begin
                if (s == win) ref_pg[s]++;
                else if (reqv[s]) ref_ps[s]++;
            end
            if (win >= 0) begin
                e.g     = cyc;
                e.src   = win;
                e.we    = f_we;
                e.err   = oor;
                e.id    = f_id;
                e.rdata = (!f_we && !oor) ? ref_mem[f_addr[AW+1:2]] : 32'h0;
                if (f_we && !oor) ref_mem[f_addr[AW+1:2]] = apply_be(ref_mem[f_addr[AW+1:2]], f_wd, f_be);
                q0.push_back(e);
                q1.push_back(e);
                ref_ptr = (win + 1) % 3;
            end
        end
        last_win = win;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_idle();
        vpu_valid  = 1'b0;
        vpu_req    = '0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_be    = 4'h0;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
        instr_req  = 1'b0;
        instr_addr = 32'h0;
    endtask

    task automatic data_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [3:0] be);
        data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wd; data_be = be;
    endtask

    function automatic logic [31:0] rand_addr();
        int          word;
        logic [31:0] a;
        if ($urandom_range(0, 15) == 0) word = MEM_WORDS + $urandom_range(0, 1000);
        else                            word = $urandom_range(0, 63);
        a = 32'(word) << 2;
        a[1:0] = 2'($urandom_range(0, 3));
        return a;
    endfunction

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 32'h0;
        for (int s = 0; s < 3; s++) begin ref_pg[s] = 0; ref_ps[s] = 0; end
        ref_ptr = 0; cyc = 0; last_win = -1;
        set_idle();
        rst = 1'b1;
        mem_clear = 1'b1;
        @(posedge clk);
        #1;
        mem_clear = 1'b0;
        run_cycle();
        run_cycle();
        rst = 1'b0;

        // Reset state: idle cycle after reset, everything quiet
        run_cycle();
        check_eq("rst_gnt", obs_gnt, 3'b000);
        check_eq("rst_mem_en", obs_mem_en, 1'b0);
        check_eq("rst_vpu_result", obs_vpu_result, 37'h0);
        check_eq("rst_data_rdata", obs_data_rdata, 32'h0);
        check_eq("rst_data_err", obs_data_err, 1'b0);

        // Scenario 1: all three hold requests for six cycles
        vpu_valid = 1'b1;
        vpu_req   = '{addr: 32'h10, we: 1'b0, be: 4'hF, wdata: 32'h0, id: 4'h1};
        data_access(1'b0, 32'h14, 32'h0, 4'hF);
        instr_req = 1'b1; instr_addr = 32'h18;
        for (int c = 0; c < 6; c++) begin
            run_cycle();
            check_eq($sformatf("t1_order%0d", c), obs_gnt, 3'b001 << (c % 3));
        end
        set_idle();
        run_cycle();
        run_cycle();

        // Scenario 2: partial-byte write then read back
        data_access(1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0101);
        run_cycle();
        check_eq("t2_wr_gnt", obs_gnt, 3'b010);
        set_idle();
        run_cycle();
        check_eq("t2_wr_rvalid", obs_data_rvalid, 1'b1);
        data_access(1'b0, 32'h100, 32'h0, 4'hF);
        run_cycle();
        set_idle();
        run_cycle();
        check_eq("t2_rd_rvalid", obs_data_rvalid, 1'b1);
        check_eq("t2_rd_rdata", obs_data_rdata, 32'h00AD_00EF);

        // Scenario 3: VPU and data read in the same cycle
        data_access(1'b1, 32'h40, 32'h1111_2222, 4'hF);
        run_cycle();
        data_access(1'b1, 32'h44, 32'h3333_4444, 4'hF);
        run_cycle();
        set_idle();
        run_cycle();
        vpu_valid = 1'b1;
        vpu_req   = '{addr: 32'h40, we: 1'b0, be: 4'hF, wdata: 32'h0, id: 4'hA};
        data_access(1'b0, 32'h44, 32'h0, 4'hF);
        run_cycle();
        check_eq("t3_first_gnt", obs_gnt, 3'b001);
        vpu_valid = 1'b0;
        run_cycle();
        check_eq("t3_second_gnt", obs_gnt, 3'b010);
        check_eq("t3_vpu_rvalid", obs_vpu_rvalid, 1'b1);
        check_eq("t3_vpu_id", obs_vpu_result.id, 4'hA);
        check_eq("t3_vpu_rdata", obs_vpu_result.rdata, 32'h1111_2222);
        set_idle();
        run_cycle();
        check_eq("t3_data_rvalid", obs_data_rvalid, 1'b1);
        check_eq("t3_data_rdata", obs_data_rdata, 32'h3333_4444);
        run_cycle();

        // Scenario 4: out-of-range write is granted, suppressed, flagged
        data_access(1'b1, 32'h8000, 32'hFFFF_FFFF, 4'hF);
        run_cycle();
        check_eq("t4_gnt", obs_gnt, 3'b010);
        check_eq("t4_mem_en", obs_mem_en, 1'b0);
        set_idle();
        run_cycle();
        check_eq("t4_rvalid", obs_data_rvalid, 1'b1);
        check_eq("t4_err", obs_data_err, 1'b1);
        data_access(1'b0, 32'h0, 32'h0, 4'hF);
        run_cycle();
        set_idle();
        run_cycle();
        check_eq("t4_word0_intact", obs_data_rdata, 32'h0);

        // Scenario 5: reset one cycle after a VPU read grant (MEM_LAT=2 instance)
        vpu_valid = 1'b1;
        vpu_req   = '{addr: 32'h40, we: 1'b0, be: 4'hF, wdata: 32'h0, id: 4'h5};
        run_cycle();
        check_eq("t5_gnt", obs_gnt, 3'b001);
        set_idle();
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        run_cycle();
        check_eq("t5_lat2_no_rvalid", vpu_rvalid_w[1], 1'b0);
        vpu_valid = 1'b1;
        vpu_req   = '{addr: 32'h44, we: 1'b0, be: 4'hF, wdata: 32'h0, id: 4'h6};
        data_access(1'b0, 32'h48, 32'h0, 4'hF);
        instr_req = 1'b1; instr_addr = 32'h4C;
        run_cycle();
        check_eq("t5_ptr_reset", obs_gnt, 3'b001);
        set_idle();
        run_cycle();
        run_cycle();

        // Randomized traffic; requesters hold until granted, occasional reset
        for (int n = 0; n < 600; n++) begin
            if (!vpu_valid && $urandom_range(0, 1) == 1) begin
                vpu_valid = 1'b1;
                vpu_req   = '{addr: rand_addr(), we: 1'($urandom_range(0, 1)), be: 4'($urandom_range(0, 15)),
                              wdata: $urandom, id: 4'($urandom_range(0, 15))};
            end
            if (!data_req && $urandom_range(0, 1) == 1) begin
                data_access(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)));
            end
            if (!instr_req && $urandom_range(0, 1) == 1) begin
                instr_req  = 1'b1;
                instr_addr = rand_addr();
            end
            rst = ($urandom_range(0, 79) == 0);
            run_cycle();
            if (last_win == 0) vpu_valid = 1'b0;
            if (last_win == 1) data_req  = 1'b0;
            if (last_win == 2) instr_req = 1'b0;
        end
        rst = 1'b0;
        set_idle();
        for (int n = 0; n < 4; n++) run_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
